// File: rtl/probe_avg_pkg.sv
// Shared types and sizing helpers for the probe block averager and its statistics sub-blocks.
package probe_avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } avg_state_t;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_LOG2_N = 4;

  // The sum of 2^log2_n signed samples needs log2_n extra bits to never wrap.
  function automatic int acc_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/probe_minmax_tracker.sv
// Running signed max/min of a sample stream; init arms the extremes, update folds in one sample.
module probe_minmax_tracker
  import probe_avg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] max_nxt,
  output logic signed [DATA_W-1:0] min_nxt
);

  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] min_q;

  // Next values include the current sample so the owner can capture final stats on the last edge.
  always_comb begin
    max_nxt = max_q;
    min_nxt = min_q;
    if (update) begin
      if (sample > max_q) max_nxt = sample;
      if (sample < min_q) min_nxt = sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      min_q <= '0;
    end else if (init) begin
      max_q <= MOST_NEG;
      min_q <= MOST_POS;
    end else if (update) begin
      max_q <= max_nxt;
      min_q <= min_nxt;
    end
  end

endmodule

// File: rtl/probe_block_averager.sv
// Block statistics over 2^LOG2_N signed probe samples: floor mean, max and min on a valid/ready port.
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last block
//   ACCUM | accepting samples (s_ready high) until N have arrived
//   DONE  | result presented (m_valid high) until m_ready
module probe_block_averager
  import probe_avg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     s_ready,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_mean,
  output logic signed [DATA_W-1:0] m_max,
  output logic signed [DATA_W-1:0] m_min,
  output logic                     busy
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_N);
  localparam int N     = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LOAD = LOG2_N'(N - 1);

  avg_state_t state_q, state_nxt;

  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  sum_nxt;
  logic signed [ACC_W-1:0]  sample_ext;
  logic [LOG2_N-1:0]        remain_q;
  logic                     launch;
  logic                     accept;
  logic                     last;
  logic signed [DATA_W-1:0] max_nxt;
  logic signed [DATA_W-1:0] min_nxt;

  assign launch     = (state_q == IDLE) && start;
  assign accept     = (state_q == ACCUM) && s_valid;
  assign last       = accept && (remain_q == '0);
  assign sample_ext = {{LOG2_N{s_data[DATA_W-1]}}, s_data};
  assign sum_nxt    = sum_q + sample_ext;

  assign s_ready = (state_q == ACCUM);
  assign m_valid = (state_q == DONE);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start)   state_nxt = ACCUM;
      ACCUM:   if (last)    state_nxt = DONE;
      DONE:    if (m_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  probe_minmax_tracker #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (launch),
    .update  (accept),
    .sample  (s_data),
    .max_nxt (max_nxt),
    .min_nxt (min_nxt)
  );

  // Down-counter holds samples still owed after the current one; zero marks the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      remain_q <= '0;
      m_mean   <= '0;
      m_max    <= '0;
      m_min    <= '0;
    end else if (launch) begin
      sum_q    <= '0;
      remain_q <= CNT_LOAD;
    end else if (accept) begin
      sum_q    <= sum_nxt;
      remain_q <= remain_q - 1'b1;
      if (last) begin
        m_mean <= DATA_W'(sum_nxt >>> LOG2_N);
        m_max  <= max_nxt;
        m_min  <= min_nxt;
      end
    end
  end

endmodule

// File: tb/tb_probe_block_averager.sv
// Directed bench for probe_block_averager with a queue-based reference model checked every cycle.
module tb_probe_block_averager;

  localparam int DATA_W = 12;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic                     s_valid = 1'b0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic                     m_ready = 1'b1;
  logic                     s_ready;
  logic                     m_valid;
  logic signed [DATA_W-1:0] m_mean;
  logic signed [DATA_W-1:0] m_max;
  logic signed [DATA_W-1:0] m_min;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  probe_block_averager #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_mean  (m_mean),
    .m_max   (m_max),
    .m_min   (m_min),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 presenting.
  int phase = 0;
  int exp_mean = 0;
  int exp_max = 0;
  int exp_min = 0;
  int blk[$];

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      exp_mean = 0;
      exp_max = 0;
      exp_min = 0;
      blk.delete();
    end else begin
      case (phase)
        0: if (start) begin
          phase = 1;
          blk.delete();
        end
        1: if (s_valid) begin
          blk.push_back(int'(s_data));
          if (blk.size() == N) begin
            int sum;
            sum = 0;
            exp_max = blk[0];
            exp_min = blk[0];
            foreach (blk[i]) begin
              sum += blk[i];
              if (blk[i] > exp_max) exp_max = blk[i];
              if (blk[i] < exp_min) exp_min = blk[i];
            end
            exp_mean = floor_div(sum, N);
            phase = 2;
          end
        end
        default: if (m_ready) phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("s_ready", int'(s_ready), int'(phase == 1));
      check("m_valid", int'(m_valid), int'(phase == 2));
      check("busy",    int'(busy),    int'(phase != 0));
      check("m_mean",  int'(m_mean),  exp_mean);
      check("m_max",   int'(m_max),   exp_max);
      check("m_min",   int'(m_min),   exp_min);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int v, input bit gap);
    s_valid = 1'b1;
    s_data  = DATA_W'(v);
    tick();
    s_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic expect_result(input string tag, input int mean, input int mx, input int mn);
    check({tag, "_valid"}, int'(m_valid), 1);
    check({tag, "_mean"},  int'(m_mean),  mean);
    check({tag, "_max"},   int'(m_max),   mx);
    check({tag, "_min"},   int'(m_min),   mn);
  endtask

  initial begin
    #12;
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_busy",    int'(busy),    0);
    check("rst_mean",    int'(m_mean),  0);
    rst_n = 1'b1;
    tick();

    // Basic block, continuous samples, consumer always ready.
    do_start();
    feed(100, 0); feed(200, 0); feed(300, 0); feed(400, 0);
    expect_result("basic", 250, 400, 100);
    tick();
    check("basic_one_cycle", int'(m_valid), 0);

    // Negative sum rounds toward negative infinity.
    do_start();
    feed(-3, 0); feed(-2, 0); feed(-2, 0); feed(-2, 0);
    expect_result("floor", -3, -2, -3);
    tick();

    do_start();
    for (int i = 0; i < N; i++) feed(2047, 0);
    expect_result("maxpos", 2047, 2047, 2047);
    tick();

    do_start();
    for (int i = 0; i < N; i++) feed(-2048, 0);
    expect_result("maxneg", -2048, -2048, -2048);
    tick();

    // Gapped input and back-pressured result; start on the handshake cycle is dropped.
    m_ready = 1'b0;
    do_start();
    feed(10, 1); feed(20, 1); feed(30, 1); feed(40, 0);
    for (int i = 0; i < 5; i++) begin
      expect_result("hold", 25, 40, 10);
      check("hold_s_ready", int'(s_ready), 0);
      tick();
    end
    m_ready = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("hs_busy", int'(busy), 0);
    tick();
    check("hs_no_restart", int'(busy), 0);

    // Start mid-block is ignored.
    do_start();
    feed(5, 0); feed(7, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(9, 0); feed(11, 0);
    expect_result("midstart", 8, 11, 5);
    tick();
    check("midstart_idle", int'(busy), 0);

    // Asynchronous reset mid-block discards the partial sum.
    do_start();
    feed(500, 0); feed(500, 0); feed(500, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s_ready", int'(s_ready), 0);
    check("arst_busy",    int'(busy),    0);
    check("arst_m_valid", int'(m_valid), 0);
    check("arst_mean",    int'(m_mean),  0);
    check("arst_max",     int'(m_max),   0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    feed(1, 0); feed(1, 0); feed(1, 0); feed(1, 0);
    expect_result("post_rst", 1, 1, 1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
